// File: rtl/seg_pipelined_adder.sv
// Wide adder/subtractor pipelined by SEG_WIDTH-bit carry-chain segments, with valid/ready on both sides.
// Optional: define SEG_PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seg_pipelined_adder #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co
`ifdef SEG_PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NUM_SEG = WIDTH / SEG_WIDTH;

  if (WIDTH % SEG_WIDTH != 0) begin : g_bad_width
    $error("seg_pipelined_adder: WIDTH must be a multiple of SEG_WIDTH");
  end
  if (SEG_WIDTH < 3) begin : g_bad_seg
    $error("seg_pipelined_adder: SEG_WIDTH must be at least 3");
  end

  function automatic logic [SEG_WIDTH:0] seg_add(input logic [SEG_WIDTH-1:0] x,
                                                 input logic [SEG_WIDTH-1:0] z,
                                                 input logic                 cin);
    return {1'b0, x} + {1'b0, z} + {{SEG_WIDTH{1'b0}}, cin};
  endfunction

  // Bits belonging to segments k and above; lower operand segments are dead once consumed.
  function automatic logic [WIDTH-1:0] hi_mask(input int k);
    return {WIDTH{1'b1}} << (k * SEG_WIDTH);
  endfunction

  logic                                w_adv;
  logic [NUM_SEG-1:0]                  r_vld_p;
  logic [NUM_SEG-1:0][WIDTH-1:0]       r_a_p;
  logic [NUM_SEG-1:0][WIDTH-1:0]       r_b_p;
  logic [NUM_SEG-1:0][WIDTH-1:0]       r_sum_p;
  logic [NUM_SEG-1:0]                  r_c_p;
  logic [NUM_SEG-1:0][SEG_WIDTH-1:0]   w_seg_s;
  logic [NUM_SEG-1:0]                  w_seg_co;
  logic                                r_out_valid;
  logic [WIDTH-1:0]                    r_y;
  logic                                r_co;

  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    logic [SEG_WIDTH:0] w_res;
    assign w_res       = seg_add(r_a_p[k][k*SEG_WIDTH +: SEG_WIDTH],
                                 r_b_p[k][k*SEG_WIDTH +: SEG_WIDTH], r_c_p[k]);
    assign w_seg_s[k]  = w_res[SEG_WIDTH-1:0];
    assign w_seg_co[k] = w_res[SEG_WIDTH];
  end

`ifdef SEG_PIPELINED_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf;
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign w_ovf = r_a_p[NUM_SEG-1][WIDTH-1] ^ r_b_p[NUM_SEG-1][WIDTH-1]
               ^ w_seg_s[NUM_SEG-1][SEG_WIDTH-1] ^ w_seg_co[NUM_SEG-1];
  assign ovf   = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p     <= '0;
      r_a_p       <= '0;
      r_b_p       <= '0;
      r_sum_p     <= '0;
      r_c_p       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_co        <= 1'b0;
`ifdef SEG_PIPELINED_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (w_adv) begin
      // p0: input capture, B inverted here so every stage sees B'
      r_vld_p[0] <= in_valid;
      if (in_valid) begin
        r_a_p[0] <= a;
        r_b_p[0] <= bi ? ~b : b;
        r_c_p[0] <= ci;
      end
      // pN: segment N-1 resolved, result bits grow upward while operand bits shrink
      for (int k = 1; k < NUM_SEG; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
        if (r_vld_p[k-1]) begin
          r_a_p[k]   <= r_a_p[k-1] & hi_mask(k);
          r_b_p[k]   <= r_b_p[k-1] & hi_mask(k);
          r_sum_p[k] <= r_sum_p[k-1] | (WIDTH'(w_seg_s[k-1]) << ((k-1) * SEG_WIDTH));
          r_c_p[k]   <= w_seg_co[k-1];
        end
      end
      // output: final segment lands directly in the result register
      r_out_valid <= r_vld_p[NUM_SEG-1];
      if (r_vld_p[NUM_SEG-1]) begin
        r_y  <= r_sum_p[NUM_SEG-1] | (WIDTH'(w_seg_s[NUM_SEG-1]) << ((NUM_SEG-1) * SEG_WIDTH));
        r_co <= w_seg_co[NUM_SEG-1];
`ifdef SEG_PIPELINED_ADDER_OVF_EN
        r_ovf <= w_ovf;
`endif
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign co        = r_co;

endmodule

// File: tb/tb_seg_pipelined_adder.sv
// Directed bench for seg_pipelined_adder (default 32-bit, 8-bit segments).
module tb_seg_pipelined_adder;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        bi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        co;
`ifdef SEG_PIPELINED_ADDER_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  seg_pipelined_adder #(.WIDTH(32), .SEG_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .bi(bi),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co)
`ifdef SEG_PIPELINED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                            input logic tbi, output logic [31:0] ry, output logic rco,
                            output logic rovf, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb_v; ci = tci; bi = tbi;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    ry  = y;
    rco = co;
`ifdef SEG_PIPELINED_ADDER_OVF_EN
    rovf = ovf;
`else
    rovf = 1'b0;
`endif
    step();
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co got %b want 0", co); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_carry_cross();
    logic [31:0] ry; logic rco, rovf; int lat;
    run_single(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, ry, rco, rovf, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got %0d want 4", lat); end
    checks++; if (ry !== 32'h01000000) begin errors++; $display("FAIL carry_y got %h want 01000000", ry); end
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL carry_co got %b want 0", rco); end
  endtask

  task automatic test_wrap();
    logic [31:0] ry; logic rco, rovf; int lat;
    run_single(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, ry, rco, rovf, lat);
    checks++; if (ry !== 32'h00000000) begin errors++; $display("FAIL wrap_y got %h want 00000000", ry); end
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL wrap_co got %b want 1", rco); end
`ifdef SEG_PIPELINED_ADDER_OVF_EN
    checks++; if (rovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", rovf); end
`endif
    run_single(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, ry, rco, rovf, lat);
    checks++; if (ry !== 32'h80000000) begin errors++; $display("FAIL maxpos_y got %h want 80000000", ry); end
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL maxpos_co got %b want 0", rco); end
`ifdef SEG_PIPELINED_ADDER_OVF_EN
    checks++; if (rovf !== 1'b1) begin errors++; $display("FAIL maxpos_ovf got %b want 1", rovf); end
`endif
  endtask

  task automatic test_subtract();
    logic [31:0] ry; logic rco, rovf; int lat;
    run_single(32'd5, 32'd7, 1'b1, 1'b1, ry, rco, rovf, lat);
    checks++; if (ry !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_5_7_y got %h want fffffffe", ry); end
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL sub_5_7_co got %b want 0", rco); end
    run_single(32'd7, 32'd5, 1'b1, 1'b1, ry, rco, rovf, lat);
    checks++; if (ry !== 32'h00000002) begin errors++; $display("FAIL sub_7_5_y got %h want 00000002", ry); end
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL sub_7_5_co got %b want 1", rco); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int hold = 0, nxt = 1, cyc = 0;
    bit seen = 0;
    while (got.size() < 6 && cyc < 60) begin
      if (out_valid === 1'b1 && !seen) begin seen = 1; hold = 3; end
      out_ready = (hold > 0) ? 1'b0 : 1'b1;
      in_valid  = (nxt <= 6);
      a = 32'(nxt); b = 32'(nxt * 16); ci = 1'b0; bi = 1'b0;
      #1;
      if (hold > 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (y !== 32'h11) begin errors++; $display("FAIL bp_hold_y got %h want 00000011", y); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(y);
      if (in_valid && in_ready === 1'b1) nxt++;
      if (hold > 0) hold--;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 32'(17 * (k + 1))) begin
        errors++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], 32'(17 * (k + 1)));
      end
    end
    step();
  endtask

  task automatic test_throughput();
    logic [31:0] ta[100], tbv[100], ey[100];
    logic        tci[100], tbi[100], eco[100];
    logic [32:0] full;
    int idx = 0, nout = 0, cyc = -1, last = -1;
    for (int k = 0; k < 100; k++) begin
      ta[k]  = $urandom; tbv[k] = $urandom;
      tci[k] = 1'($urandom_range(0, 1)); tbi[k] = 1'($urandom_range(0, 1));
      full   = {1'b0, ta[k]} + {1'b0, (tbi[k] ? ~tbv[k] : tbv[k])} + {32'h0, tci[k]};
      ey[k]  = full[31:0]; eco[k] = full[32];
    end
    out_ready = 1'b1;
    while (nout < 100 && cyc < 200) begin
      if (idx < 100) begin
        in_valid = 1'b1; a = ta[idx]; b = tbv[idx]; ci = tci[idx]; bi = tbi[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
      cyc++;
      if (out_valid === 1'b1) begin
        checks++;
        if (y !== ey[nout] || co !== eco[nout]) begin
          errors++; $display("FAIL tp_beat[%0d] got %h/%b want %h/%b", nout, y, co, ey[nout], eco[nout]);
        end
        nout++;
        last = cyc;
      end
    end
    in_valid = 1'b0;
    checks++; if (nout !== 100) begin errors++; $display("FAIL tp_count got %0d want 100", nout); end
    checks++; if (last !== 103) begin errors++; $display("FAIL tp_cycles got %0d want 103", last); end
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; a = 32'(k * 256 + 3); b = 32'h1; ci = 1'b0; bi = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || y !== 32'h104) begin errors++; $display("FAIL mid_pre_out got %b/%h want 1/00000104", out_valid, y); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL mid_rst_y got %h want 00000000", y); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL mid_rst_co got %b want 0", co); end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got %b want 0", k, out_valid); end
      step();
    end
  endtask

  task automatic test_after_reset();
    logic [31:0] ry; logic rco, rovf; int lat;
    run_single(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, ry, rco, rovf, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_latency got %0d want 4", lat); end
    checks++; if (ry !== 32'h21436588) begin errors++; $display("FAIL post_y got %h want 21436588", ry); end
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL post_co got %b want 0", rco); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; bi = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_carry_cross();
    test_wrap();
    test_subtract();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
